frame_loader: RTL and testbench

Input-capture stage directly upstream of the convolution layer. Builds a 6x6 binary input frame one row at a time from six slide switches and a load push-button, then presents the completed frame to the convolution layer through a valid/ready handshake. Also provides a clear button, a row-index output for LED display, and a sticky overrun flag.

---
 rtl/frame_pkg.sv | 8 +
 rtl/frame_loader_debounce.sv | 41 ++++
 rtl/frame_loader.sv | 78 +++++++
 tb/tb_frame_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared sizes, FSM state and frame type for the frame loader
package frame_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int ROW_IDX_W = 3;
  typedef enum logic {FILL, FULL} state_t;
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;
endpackage

// File: rtl/frame_loader_debounce.sv
// btn_debounce: synchronizes a raw button and emits one pulse per accepted press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_level;
  logic r_pulse;
  logic w_done;
  assign w_done = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign pulse = r_pulse;
  // level is accepted only after the synced input differs from it for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn_raw};
      r_pulse <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (w_done) begin
          r_level <= r_sync[1];
          r_cnt <= '0;
          r_pulse <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/frame_loader.sv
// frame_loader: builds a 6x6 binary frame row by row and hands it off via valid/ready
module frame_loader
  import frame_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COLS-1:0]        sw_row,
  input  logic                   btn_load,
  input  logic                   btn_clear,
  input  logic                   frame_ready,
  output logic [ROWS*COLS-1:0]   data_out,
  output logic                   frame_valid,
  output logic [ROW_IDX_W-1:0]   row_idx,
  output logic                   overrun
);
  logic [COLS-1:0] r_sw0;
  logic [COLS-1:0] r_sw1;
  frame_t r_frame;
  logic [ROW_IDX_W-1:0] r_row;
  logic r_ovr;
  state_t r_state;
  state_t w_state_nxt;
  logic w_load;
  logic w_clear;
  logic w_last;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_load), .pulse(w_load)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .pulse(w_clear)
  );
  assign w_last = r_row == ROW_IDX_W'(ROWS - 1);
  assign data_out = r_frame;
  assign frame_valid = r_state == FULL;
  assign row_idx = r_row;
  assign overrun = r_ovr;
  // two-stage synchronizer for the asynchronous switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw0 <= '0;
      r_sw1 <= '0;
    end else begin
      r_sw0 <= sw_row;
      r_sw1 <= r_sw0;
    end
  end
  // state register; frame_valid is simply the FULL state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else r_state <= w_state_nxt;
  end
  // next state: clear wins, last-row load fills, ready drains
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) w_state_nxt = FILL;
    else if (r_state == FILL && w_load && w_last) w_state_nxt = FULL;
    else if (r_state == FULL && frame_ready) w_state_nxt = FILL;
  end
  // frame rows, row pointer and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_row <= '0;
      r_ovr <= 1'b0;
    end else if (w_clear) begin
      r_frame <= '0;
      r_row <= '0;
      r_ovr <= 1'b0;
    end else if (r_state == FILL && w_load) begin
      r_frame[r_row] <= r_sw1;
      r_row <= w_last ? '0 : r_row + 1'b1;
    end else if (r_state == FULL && w_load) begin
      r_ovr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed self-checking bench for frame_loader
module tb_frame_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] sw_row = '0;
  logic btn_load = 1'b0;
  logic btn_clear = 1'b0;
  logic frame_ready = 1'b0;
  logic [35:0] data_out;
  logic frame_valid;
  logic [2:0] row_idx;
  logic overrun;
  int total = 0;
  int bad = 0;
  logic [35:0] full_ramp;
  logic [35:0] d_hold;
  frame_loader #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw_row(sw_row), .btn_load(btn_load),
    .btn_clear(btn_clear), .frame_ready(frame_ready), .data_out(data_out),
    .frame_valid(frame_valid), .row_idx(row_idx), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic ld, input logic cl, input logic [5:0] sw);
    @(negedge clk);
    sw_row = sw;
    btn_load = ld;
    btn_clear = cl;
    repeat (24) @(negedge clk);
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (24) @(negedge clk);
  endtask
  task automatic ramp_fill();
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0, 6'((1 << (i + 1)) - 1));
      chk($sformatf("ramp_row%0d", i), row_idx, (i + 1) % 6);
    end
  endtask
  initial begin
    full_ramp = 36'hFDF3C70C1;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ramp_fill();
    chk("ramp_valid", frame_valid, 1);
    chk("ramp_data", data_out, full_ramp);
    repeat (100) @(negedge clk);
    chk("hold_valid", frame_valid, 1);
    chk("hold_data", data_out, full_ramp);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("xfer_valid", frame_valid, 0);
    chk("xfer_row", row_idx, 0);
    chk("xfer_data", data_out, full_ramp);
    press(1'b1, 1'b0, 6'b101010);
    chk("reload_row0", data_out[5:0], 6'b101010);
    chk("reload_rest", data_out[35:6], full_ramp[35:6]);
    chk("reload_idx", row_idx, 1);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 6'h15);
    chk("fill2_valid", frame_valid, 1);
    d_hold = {6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h2A};
    chk("fill2_data", data_out, d_hold);
    press(1'b1, 1'b0, 6'h00);
    chk("ovr_set", overrun, 1);
    chk("ovr_data", data_out, d_hold);
    chk("ovr_valid", frame_valid, 1);
    chk("ovr_row", row_idx, 0);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("ovr_after_xfer", overrun, 1);
    chk("ovr_xfer_valid", frame_valid, 0);
    press(1'b0, 1'b1, 6'h00);
    chk("clr_ovr", overrun, 0);
    chk("clr_data", data_out, 0);
    chk("clr_row", row_idx, 0);
    @(negedge clk);
    sw_row = 6'h33;
    for (int i = 0; i < 5; i++) begin
      btn_load = 1'b1;
      repeat (4) @(negedge clk);
      btn_load = 1'b0;
      repeat (4) @(negedge clk);
    end
    btn_load = 1'b1;
    repeat (24) @(negedge clk);
    btn_load = 1'b0;
    repeat (24) @(negedge clk);
    chk("bounce_row", row_idx, 1);
    chk("bounce_data", data_out, 36'h33);
    press(1'b1, 1'b0, 6'h0C);
    press(1'b1, 1'b0, 6'h21);
    chk("pre_cl_row", row_idx, 3);
    chk("pre_cl_data", data_out, 36'h21333);
    press(1'b1, 1'b1, 6'h3F);
    chk("cl_ld_row", row_idx, 0);
    chk("cl_ld_data", data_out, 0);
    chk("cl_ld_valid", frame_valid, 0);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 6'h3F);
    chk("pre_rst_row", row_idx, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_row", row_idx, 0);
    chk("arst_valid", frame_valid, 0);
    chk("arst_ovr", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ramp_fill();
    chk("post_rst_valid", frame_valid, 1);
    chk("post_rst_data", data_out, full_ramp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
